// File: rtl/coincidence_counter_if.sv
// Snapshot bank and Valid/Ack handshake between the coincidence counter and its consumer.
interface coincidence_counter_if #(
   parameter int NCHAN = 5,
   parameter int CBITS = 16
);
   localparam int NPAIRS = NCHAN * (NCHAN - 1) / 2;

   logic [NPAIRS*CBITS-1:0] Counts;
   logic [NCHAN*CBITS-1:0]  Singles;
   logic                    Valid;
   logic                    Ack;
   logic                    Overrun;
   logic                    Saturated;

   modport master (
      output Counts, Singles, Valid, Overrun, Saturated,
      input  Ack
   );

   modport slave (
      input  Counts, Singles, Valid, Overrun, Saturated,
      output Ack
   );
endinterface

// File: rtl/coincidence_counter.sv
// Coincidence counter: per-channel delay alignment, edge detection, window stretching,
// gated accumulation of singles and pairwise coincidences, snapshot bank with handshake.
module coincidence_counter #(
   parameter int NCHAN = 5,
   parameter int NBITS = 6,
   parameter int WBITS = 4,
   parameter int CBITS = 16,
   parameter int PBITS = 24
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   En,
   input  logic [NCHAN-1:0]       Channels,
   input  logic [NCHAN*NBITS-1:0] Delays,
   input  logic [WBITS-1:0]       Window,
   input  logic [PBITS-1:0]       Period,
   coincidence_counter_if.master  bus
);
   localparam int NPAIRS = NCHAN * (NCHAN - 1) / 2;
   localparam int DEPTH  = 2 ** NBITS;
   localparam logic [CBITS-1:0] CMAX = '1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Lexicographic index of pair (i,j), i<j.
   function automatic int pair_idx(int i, int j);
      return i * NCHAN - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   logic [NCHAN-1:0] ch_q;
   logic [DEPTH-1:0] dly_q [NCHAN];
   logic [NCHAN-1:0] pulse_q;
   logic [WBITS-1:0] stretch_q [NCHAN];
   logic [WBITS-1:0] wlen;
   logic [NCHAN-1:0] win;

   logic [NPAIRS-1:0] pair_win;
   logic [NPAIRS-1:0] pair_win_q;
   logic [NPAIRS-1:0] pair_evt;

   logic [CBITS-1:0] pair_acc_q [NPAIRS];
   logic [CBITS-1:0] single_acc_q [NCHAN];
   logic [CBITS-1:0] pair_nxt [NPAIRS];
   logic [CBITS-1:0] single_nxt [NCHAN];
   logic             sat_q;
   logic             sat_inc;

   logic [0:0]       state_q;
   logic [PBITS-1:0] gate_q;
   logic             snap_now;

   logic [NPAIRS*CBITS-1:0] counts_q;
   logic [NCHAN*CBITS-1:0]  singles_q;
   logic                    valid_q;
   logic                    overrun_q;
   logic                    saturated_q;

   // Edge detect and per-channel delay line; runs independently of En.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ch_q    <= '0;
         pulse_q <= '0;
         for (int c = 0; c < NCHAN; c++) dly_q[c] <= '0;
      end else begin
         ch_q <= Channels;
         for (int c = 0; c < NCHAN; c++) begin
            dly_q[c]   <= {dly_q[c][DEPTH-2:0], Channels[c] & ~ch_q[c]};
            pulse_q[c] <= dly_q[c][Delays[c*NBITS +: NBITS]];
         end
      end
   end

   assign wlen = (Window == '0) ? WBITS'(1) : Window;

   // Stretch each pulse into a window; a new pulse reloads an open window.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int c = 0; c < NCHAN; c++) stretch_q[c] <= '0;
      end else begin
         for (int c = 0; c < NCHAN; c++) begin
            if (pulse_q[c]) begin
               stretch_q[c] <= wlen - WBITS'(1);
            end else if (stretch_q[c] != '0) begin
               stretch_q[c] <= stretch_q[c] - WBITS'(1);
            end
         end
      end
   end

   // Window is open in the pulse cycle and while the stretch counter is nonzero.
   always_comb begin
      for (int c = 0; c < NCHAN; c++) win[c] = pulse_q[c] | (stretch_q[c] != '0);
   end

   // Pairwise window overlap; an event is the rising edge of the overlap.
   always_comb begin
      pair_win = '0;
      for (int i = 0; i < NCHAN; i++) begin
         for (int j = i + 1; j < NCHAN; j++) begin
            pair_win[pair_idx(i, j)] = win[i] & win[j];
         end
      end
   end

   assign pair_evt = pair_win & ~pair_win_q;

   // Previous-cycle overlap, for rising-edge detection of pair events.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) pair_win_q <= '0;
      else        pair_win_q <= pair_win;
   end

   // Saturating next values; sat_inc flags an event lost at full scale.
   always_comb begin
      sat_inc = 1'b0;
      for (int k = 0; k < NPAIRS; k++) begin
         pair_nxt[k] = pair_acc_q[k];
         if (pair_evt[k]) begin
            if (pair_acc_q[k] == CMAX) sat_inc = 1'b1;
            else                       pair_nxt[k] = pair_acc_q[k] + CBITS'(1);
         end
      end
      for (int c = 0; c < NCHAN; c++) begin
         single_nxt[c] = single_acc_q[c];
         if (pulse_q[c]) begin
            if (single_acc_q[c] == CMAX) sat_inc = 1'b1;
            else                         single_nxt[c] = single_acc_q[c] + CBITS'(1);
         end
      end
   end

   assign snap_now = (state_q == ST_RUN) && En && (Period != '0) &&
                     (gate_q == Period - PBITS'(1));

   // IDLE/RUN control, gate counter and accumulators.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= ST_IDLE;
         gate_q  <= '0;
         sat_q   <= 1'b0;
         for (int k = 0; k < NPAIRS; k++) pair_acc_q[k] <= '0;
         for (int c = 0; c < NCHAN; c++) single_acc_q[c] <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (En) begin
                  state_q <= ST_RUN;
                  gate_q  <= '0;
                  sat_q   <= 1'b0;
                  for (int k = 0; k < NPAIRS; k++) pair_acc_q[k] <= '0;
                  for (int c = 0; c < NCHAN; c++) single_acc_q[c] <= '0;
               end
            end
            default: begin
               if (!En) begin
                  state_q <= ST_IDLE;
               end else if (snap_now) begin
                  gate_q <= '0;
                  sat_q  <= 1'b0;
                  for (int k = 0; k < NPAIRS; k++) pair_acc_q[k] <= '0;
                  for (int c = 0; c < NCHAN; c++) single_acc_q[c] <= '0;
               end else begin
                  gate_q <= gate_q + PBITS'(1);
                  sat_q  <= sat_q | sat_inc;
                  for (int k = 0; k < NPAIRS; k++) pair_acc_q[k] <= pair_nxt[k];
                  for (int c = 0; c < NCHAN; c++) single_acc_q[c] <= single_nxt[c];
               end
            end
         endcase
      end
   end

   // Snapshot bank and Valid/Overrun handshake; a snapshot setting Overrun wins over Ack.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         counts_q    <= '0;
         singles_q   <= '0;
         saturated_q <= 1'b0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (snap_now) begin
            for (int k = 0; k < NPAIRS; k++) counts_q[k*CBITS +: CBITS] <= pair_nxt[k];
            for (int c = 0; c < NCHAN; c++) singles_q[c*CBITS +: CBITS] <= single_nxt[c];
            saturated_q <= sat_q | sat_inc;
            valid_q     <= 1'b1;
            if (valid_q && !bus.Ack) overrun_q <= 1'b1;
         end else if (valid_q && bus.Ack) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
         end
      end
   end

   assign bus.Counts    = counts_q;
   assign bus.Singles   = singles_q;
   assign bus.Valid     = valid_q;
   assign bus.Overrun   = overrun_q;
   assign bus.Saturated = saturated_q;

endmodule

// File: doc/coincidence_counter.md
# coincidence_counter

Second-generation coincidence counter for the detector front end. Aligns NCHAN digital channels with per-channel programmable delays and detects rising edges. Stretches each edge into a programmable coincidence window, then accumulates singles and all pairwise coincidences over a programmable gate period. Each period ends in a snapshot bank read through a Valid/Ack handshake with overrun and saturation flags.

## Interface
- NCHAN, 5, number of input channels (≥2); NPAIRS = NCHAN*(NCHAN-1)/2 derived
- NBITS, 6, delay width; per-channel delay 0..2^NBITS-1 cycles
- WBITS, 4, coincidence window width
- CBITS, 16, count width of every accumulator and snapshot
- PBITS, 24, gate period width

- Clk  in  1  single clock; all logic on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- En  in  1  run enable
- Channels  in  NCHAN  raw channel inputs, synchronous to Clk
- Delays  in  NBITS x NCHAN  per-channel delay, static while En=1
- Window  in  WBITS  coincidence window length in cycles, static while En=1
- Period  in  PBITS  gate length in cycles, static while En=1
- Counts  out  CBITS x NPAIRS  pair snapshot; pair (i,j), i<j, enumerated lexicographically: (0,1)=0, (0,2)=1 … (NCHAN-2,NCHAN-1)=NPAIRS-1
- Singles  out  CBITS x NCHAN  per-channel edge count snapshot
- Valid  out  1  snapshot available
- Ack  in  1  consumer accepts snapshot
- Overrun  out  1  sticky: snapshot overwritten before Ack
- Saturated  out  1  some accumulator saturated during the snapshotted gate

## Operation
- Edge/delay: rising edge of Channels[i] sampled at edge t (low at t-1) → one-cycle pulse P_i high in the cycle after edge t+1+Delays[i]. Delay path and edge detection run regardless of En.
- Window: P_i loads stretch counter with max(Window,1). W_i is high in the P_i cycle and the following max(Window,1)-1 cycles. A new P_i during an open window reloads it.
- Pair event E_ij: cycle where W_i & W_j is high and was low the previous cycle. With Window≤1 this reduces to P_i & P_j in the same cycle.
- Single event: P_i.
- Accumulators (NPAIRS + NCHAN): +1 per event. Saturate at 2^CBITS-1, never wrap; saturation sets an internal sat flag.
- FSM IDLE/RUN:
  - IDLE: accumulators and gate counter G hold; events discarded.
  - IDLE→RUN on En=1: accumulators, sat flag, and G cleared at that edge.
  - RUN→IDLE on En=0: no snapshot; partial data discarded at next RUN entry.
- Gate: G increments each RUN cycle. At the edge where G==Period-1:
  - Counts/Singles ← accumulator + event of that cycle (saturating); Saturated ← sat flag including that cycle.
  - accumulators, sat flag, G ← 0; Valid ← 1.
- Period=0: gating disabled; accumulators count, no snapshot ever.
- Handshake: Valid stays high until Ack sampled with Valid=1, then clears at that edge. Ack with Valid=0 is ignored.
- Snapshot while Valid=1 and Ack=0: bank overwritten, Valid stays 1, Overrun ← 1.
- Snapshot and Ack in the same cycle: new bank loaded, Valid stays 1, Overrun unchanged.
- Overrun clears on the accepting Ack edge unless a snapshot in the same cycle sets it again. Set has priority.

## Timing
- Reset: Counts, Singles, Valid, Overrun, Saturated = 0; FSM IDLE; delay lines, edge registers, stretch counters, accumulators, G cleared. Asynchronous, effective mid-operation; the first RUN entry after release starts a fresh gate.
- Latency, input edge to pulse: Channels edge sampled at t → P_i in cycle t+1+Delays[i].
- Latency, event to accumulator: event in cycle c is visible in the accumulator after edge c+1.
- Gate length: first snapshot lands Period cycles after the En-rising edge that entered RUN.
- Snapshot spacing: exactly Period cycles.
- Outputs are registered; Counts/Singles change only on snapshot edges and reset.
- Changing Delays/Window/Period while En=1 is unsupported; results are undefined until the next RUN entry.

## Test plan
- Reset, stimulus: assert Rst_n=0 mid-RUN with Valid=1. Required: all outputs 0 asynchronously; after release, En=1 yields a first snapshot exactly Period cycles later.
- Basic coincidences, stimulus: Delays=0, Window=1, Period=100; 3 simultaneous edges on ch0/ch1. Required: Counts[0]=3, Singles[0]=Singles[1]=3, all others 0, Valid=1 at cycle 100.
- Delay alignment, stimulus: ch2 edge 5 cycles before ch3.
  - Delays[2]=5, Window=1 → Counts[7]=1.
  - Delays[2]=4, Window=1 → Counts[7]=0.
  - Delays[2]=4, Window=2 → Counts[7]=1.
- Window length, stimulus: ch1 edge 3 cycles after ch0. Required: Window=3 → Counts[0]=0; Window=4 → Counts[0]=1; a retriggered ch0 keeps the window open.
- Handshake:
  - No Ack across two periods → Overrun=1 and bank holds second-gate values; Ack → Valid=0, Overrun=0 next cycle.
  - Ack coincident with a snapshot → Valid stays 1, Overrun stays 0.
- Saturation and enable, stimulus: CBITS=4, 20 ch0/ch1 coincidences. Required: Counts[0]=15, Saturated=1.
- Enable drop, stimulus: drop En mid-gate, then raise it. Required: no snapshot; the next gate counts from 0.
